// File: rtl/ssy_rr_arbiter_if.sv
// Requester/resource signal bundle for ssy_rr_arbiter.
// The master modport is the arbiter's view; slave is the requester/resource side.
interface ssy_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           res_request;
  logic           res_idle;
  logic           res_granted;
  logic           timeout_err;

  modport master (
    input  req, res_idle, res_granted,
    output gnt, gnt_id, busy, res_request, timeout_err
  );

  modport slave (
    output req, res_idle, res_granted,
    input  gnt, gnt_id, busy, res_request, timeout_err
  );
endinterface

// File: rtl/ssy_rr_arbiter.sv
// Round-robin arbiter in front of one ssy request/idle/granted resource.
// Optional macro ARB_TIMEOUT_EN adds a WAIT-state timeout with a timeout_err pulse.
module ssy_rr_arbiter #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  ssy_rr_arbiter_if.master arb
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OWN} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic           res_request_q, res_request_d;

  logic [IDW-1:0] winner;
  logic           winner_vld;
  logic [IDW-1:0] idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  // Search starts just after the previous owner, so it is the last candidate.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    idx        = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDW'((int'(last_q) + i) % N);
      if (!winner_vld && arb.req[idx]) begin
        winner     = idx;
        winner_vld = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, otherwise a path
  // through the case statement that skips an assignment would infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    busy_d        = busy_q;
    res_request_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb.res_idle && winner_vld) begin
          owner_d       = winner;
          busy_d        = 1'b1;
          res_request_d = 1'b1;
          state_d       = S_ISSUE;
`ifdef ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (arb.res_granted) begin
          gnt_d   = N'(1) << owner_q;
          state_d = S_OWN;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Owner forfeits its turn; it becomes lowest priority next round.
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          last_d        = owner_q;
          state_d       = S_IDLE;
        end
`endif
      end
      S_OWN: begin
        if (!arb.req[owner_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_q        <= IDW'(N - 1);
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      res_request_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      res_request_q <= res_request_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign arb.timeout_err = timeout_err_q;
`else
  assign arb.timeout_err = 1'b0;
`endif

  assign arb.gnt         = gnt_q;
  assign arb.gnt_id      = owner_q;
  assign arb.busy        = busy_q;
  assign arb.res_request = res_request_q;

endmodule

// File: tb/tb_ssy_rr_arbiter.sv
// Self-checking bench for ssy_rr_arbiter: directed scenarios plus randomized
// rounds checked against a rotation-based round-robin model.
module tb_ssy_rr_arbiter;
  localparam int N           = 4;
  localparam int IDW         = 2;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   last_m;

  ssy_rr_arbiter_if #(.N(N), .IDW(IDW)) arb ();

  ssy_rr_arbiter #(.N(N), .IDW(IDW), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (arb)
  );

  always #5 clk = ~clk;

  // At most one grant bit, and only while busy.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      compared++;
      if ($countones(arb.gnt) > 1 || (arb.gnt !== '0 && arb.busy !== 1'b1)) begin
        mismatched++;
        $display("FAIL gnt_onehot: gnt=%b busy=%b, required at most one bit and busy=1", arb.gnt, arb.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: rotate the request vector so the search starts after last.
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    logic [2*N-1:0] dbl;
    dbl = {r, r} >> (last + 1);
    for (int k = 0; k < N; k++)
      if (dbl[k]) return (last + 1 + k) % N;
    return -1;
  endfunction

  task automatic reset_dut();
    reset           = 1'b1;
    arb.req         = '0;
    arb.res_idle    = 1'b0;
    arb.res_granted = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    last_m = N - 1;
  endtask

  // One full ownership round for requester exp; caller has already set req.
  task automatic do_round(input int exp, input int max_wait, input int gdelay,
                          input int hold, input bit scramble);
    logic [N-1:0]     exp_gnt;
    logic [N+IDW+2:0] act, want;
    bit               seen;
    exp_gnt = '0;
    exp_gnt[exp] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < max_wait && !seen; i++) begin
      tick();
      seen = (arb.res_request === 1'b1);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL res_request_wait: no res_request within %0d cycles, required one", max_wait);
      arb.req = '0;
      return;
    end
    act  = {arb.res_request, arb.gnt, arb.busy, arb.gnt_id, arb.timeout_err};
    want = {1'b1, {N{1'b0}}, 1'b1, IDW'(exp), 1'b0};
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL issue_state: {req,gnt,busy,id,to}=%b, required %b", act, want);
    end
    for (int i = 1; i < gdelay; i++) begin
      if (scramble) arb.req = N'($urandom);
      tick();
      act  = {arb.res_request, arb.gnt, arb.busy, arb.gnt_id, arb.timeout_err};
      want = {1'b0, {N{1'b0}}, 1'b1, IDW'(exp), 1'b0};
      compared++;
      if (act !== want) begin
        mismatched++;
        $display("FAIL wait_state: {req,gnt,busy,id,to}=%b, required %b", act, want);
      end
    end
    arb.res_granted = 1'b1;
    if (scramble) arb.req = N'($urandom) | exp_gnt;
    tick();
    arb.res_granted = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      act  = {arb.res_request, arb.gnt, arb.busy, arb.gnt_id, arb.timeout_err};
      want = {1'b0, exp_gnt, 1'b1, IDW'(exp), 1'b0};
      compared++;
      if (act !== want) begin
        mismatched++;
        $display("FAIL own_state: {req,gnt,busy,id,to}=%b, required %b", act, want);
      end
      if (i < hold) begin
        if (scramble) arb.req = N'($urandom) | exp_gnt;
        tick();
      end
    end
    arb.req[exp] = 1'b0;
    tick();
    act  = {arb.res_request, arb.gnt, arb.busy, arb.gnt_id, arb.timeout_err};
    want = {1'b0, {N{1'b0}}, 1'b0, IDW'(exp), 1'b0};
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL release: {req,gnt,busy,id,to}=%b, required %b", act, want);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    arb.res_idle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if ({arb.gnt, arb.gnt_id, arb.busy, arb.res_request, arb.timeout_err} !== '0) begin
        mismatched++;
        $display("FAIL reset_idle: gnt=%b id=%0d busy=%b rq=%b to=%b, required all 0",
                 arb.gnt, arb.gnt_id, arb.busy, arb.res_request, arb.timeout_err);
      end
    end
  endtask

  task automatic test_single();
    arb.req = 4'b0001;
    do_round(model_pick(4'b0001, last_m), 1, 3, 2, 1'b0);
    last_m = 0;
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    arb.res_idle = 1'b1;
    for (int r = 0; r < 5; r++) begin
      arb.req = 4'b1111;
      do_round(order[r], 1, 2, 2, 1'b0);
    end
    arb.req = '0;
    last_m  = 0;
  endtask

  task automatic test_res_busy();
    arb.req      = 4'b0010;
    arb.res_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (arb.res_request !== 1'b0 || arb.busy !== 1'b0) begin
        mismatched++;
        $display("FAIL res_not_idle: rq=%b busy=%b, required 0 0", arb.res_request, arb.busy);
      end
    end
    arb.res_idle = 1'b1;
    do_round(model_pick(4'b0010, last_m), 1, 3, 1, 1'b0);
    last_m = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] pat;
    int           exp;
    for (int r = 0; r < 40; r++) begin
      pat          = N'($urandom_range(1, 15));
      arb.req      = pat;
      arb.res_idle = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        tick();
        compared++;
        if (arb.res_request !== 1'b0 || arb.busy !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_not_idle: rq=%b busy=%b, required 0 0", arb.res_request, arb.busy);
        end
      end
      arb.res_idle = 1'b1;
      exp = model_pick(pat, last_m);
      do_round(exp, 1, int'($urandom_range(2, 6)), int'($urandom_range(0, 3)), 1'b1);
      last_m = exp;
    end
    arb.req = '0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int dist;
    reset_dut();
    arb.req      = 4'b0101;
    arb.res_idle = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      seen = (arb.res_request === 1'b1);
    end
    compared++;
    if (!seen || arb.gnt_id !== IDW'(0)) begin
      mismatched++;
      $display("FAIL to_issue: seen=%b id=%0d, required 1 0", seen, arb.gnt_id);
    end
    dist = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (arb.timeout_err === 1'b1) begin
        seen = 1'b1;
        dist = i;
      end
    end
    compared++;
    if (dist != TIMEOUT_CYC) begin
      mismatched++;
      $display("FAIL to_distance: timeout_err after %0d cycles, required %0d", dist, TIMEOUT_CYC);
    end
    compared++;
    if (arb.busy !== 1'b0 || arb.gnt !== '0) begin
      mismatched++;
      $display("FAIL to_abort: busy=%b gnt=%b, required 0 0000", arb.busy, arb.gnt);
    end
    last_m = 0;
    // Grant arriving on the timeout cycle itself must win.
    do_round(model_pick(4'b0101, last_m), 1, TIMEOUT_CYC, 1, 1'b0);
    arb.req = '0;
  endtask
`endif

  task automatic test_reset_in_own();
    bit seen;
    reset_dut();
    arb.req      = 4'b0100;
    arb.res_idle = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      seen = (arb.res_request === 1'b1);
    end
    tick();
    arb.res_granted = 1'b1;
    tick();
    arb.res_granted = 1'b0;
    compared++;
    if (!seen || arb.gnt !== 4'b0100) begin
      mismatched++;
      $display("FAIL own_before_reset: seen=%b gnt=%b, required 1 0100", seen, arb.gnt);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({arb.gnt, arb.busy, arb.res_request} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: gnt=%b busy=%b rq=%b, required 0000 0 0",
               arb.gnt, arb.busy, arb.res_request);
    end
    tick();
    reset   = 1'b0;
    arb.req = '0;
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    arb.req         = '0;
    arb.res_idle    = 1'b0;
    arb.res_granted = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_res_busy();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_own();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
